// File: rtl/clk_div_meter.sv
// Divided-clock checker: measures period and high time of sig_in in clk units and flags lock.
// Define DUAL_EDGE_EN for half-cycle resolution using an additional negedge sampling chain.
module clk_div_meter #(
   parameter int CNT_W      = 16,
   parameter int EXP_PERIOD = 55,
   parameter int TOL        = 1,
   parameter int TIMEOUT    = 1023
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             sig_in,
   output logic [CNT_W-1:0] period,
   output logic [CNT_W-1:0] high_time,
   output logic             meas_valid,
   output logic             locked,
   output logic             timeout
);

   typedef enum logic [1:0] {IDLE, ARM, HIGH, LOW} state_t;

   localparam logic [CNT_W-1:0] EXP_V = CNT_W'(EXP_PERIOD);
   localparam logic [CNT_W-1:0] TOL_V = CNT_W'(TOL);
   localparam logic [CNT_W-1:0] TMO_V = CNT_W'(TIMEOUT);

   state_t           state_q, state_d;
   logic             sync1, sync2, sync_d;
   logic             rise, fall;
   logic [CNT_W-1:0] cnt, cnt_load, corr, meas, diff;
   logic             in_tol, prev_ok;
   logic             cap_period, cap_high, to_fire;

   // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1  <= 1'b0;
         sync2  <= 1'b0;
         sync_d <= 1'b0;
      end else begin
         sync1  <= sig_in;
         sync2  <= sync1;
         sync_d <= sync2;
      end
   end

   assign rise = sync2 & ~sync_d;
   assign fall = ~sync2 & sync_d;

`ifdef DUAL_EDGE_EN
   localparam logic [CNT_W-1:0] STEP = CNT_W'(2);
   logic neg1, neg2, neg_q;

   always_ff @(negedge clk or negedge rst_n) begin
      if (!rst_n) begin
         neg1 <= 1'b0;
         neg2 <= 1'b0;
      end else begin
         neg1 <= sig_in;
         neg2 <= neg1;
      end
   end

   // neg_q holds the sample taken half a cycle before sync2, so it shows whether the edge came earlier
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) neg_q <= 1'b0;
      else        neg_q <= neg2;
   end

   assign cnt_load = STEP + {{(CNT_W-1){1'b0}}, neg_q};
   assign corr     = {{(CNT_W-1){1'b0}}, rise ? neg_q : ~neg_q};
`else
   localparam logic [CNT_W-1:0] STEP = CNT_W'(1);
   assign cnt_load = STEP;
   assign corr     = '0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                 cnt <= '0;
      else if (rise)              cnt <= cnt_load;
      else if (cnt >= TMO_V - STEP) cnt <= TMO_V;
      else                        cnt <= cnt + STEP;
   end

   assign meas   = cnt - corr;
   assign diff   = (meas > EXP_V) ? (meas - EXP_V) : (EXP_V - meas);
   assign in_tol = (diff <= TOL_V);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // NOTE: every output of this block gets a default first so no latch is inferred.
   always_comb begin
      state_d    = state_q;
      cap_period = 1'b0;
      cap_high   = 1'b0;
      to_fire    = 1'b0;
      if (!en) begin
         state_d = IDLE;
      end else begin
         unique case (state_q)
            IDLE: state_d = ARM;
            ARM:  if (rise) state_d = HIGH;
            HIGH: begin
               if (fall) begin
                  cap_high = 1'b1;
                  state_d  = LOW;
               end else if (cnt == TMO_V) begin
                  to_fire = 1'b1;
                  state_d = ARM;
               end
            end
            LOW: begin
               if (rise) begin
                  cap_period = 1'b1;
                  state_d    = HIGH;
               end else if (cnt == TMO_V) begin
                  to_fire = 1'b1;
                  state_d = ARM;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         period     <= '0;
         high_time  <= '0;
         meas_valid <= 1'b0;
         locked     <= 1'b0;
         timeout    <= 1'b0;
         prev_ok    <= 1'b0;
      end else begin
         meas_valid <= cap_period;
         if (cap_high) high_time <= meas;
         if (cap_period) begin
            period  <= meas;
            timeout <= 1'b0;
            locked  <= prev_ok & in_tol;
            prev_ok <= in_tol;
         end else if (to_fire || !en) begin
            locked  <= 1'b0;
            prev_ok <= 1'b0;
            if (to_fire) timeout <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_clk_div_meter.sv
// Scoreboard bench for clk_div_meter: each driven rising edge queues the measurement it completes.
// With DUAL_EDGE_EN defined only the reset and half-cycle scenarios run.
module tb_clk_div_meter;

   localparam int CNT_W = 16;
`ifdef DUAL_EDGE_EN
   localparam int EXP = 110;
`else
   localparam int EXP = 55;
`endif
   localparam int TOL = 1;
   localparam int TMO = 1023;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             en = 1'b0;
   logic             sig_in = 1'b0;
   logic [CNT_W-1:0] period, high_time;
   logic             meas_valid, locked, timeout;

   clk_div_meter #(
      .CNT_W(CNT_W), .EXP_PERIOD(EXP), .TOL(TOL), .TIMEOUT(TMO)
   ) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .sig_in(sig_in),
      .period(period), .high_time(high_time), .meas_valid(meas_valid),
      .locked(locked), .timeout(timeout)
   );

   always #5 clk = ~clk;

   typedef struct {
      int p;
      int h;
      bit lk;
   } exp_t;

   exp_t q[$];
   exp_t mon_e;
   int   checks = 0;
   int   failures = 0;

   bit   have_prev = 1'b0;
   bit   prev_ok_m = 1'b0;
   int   prev_p = 0;
   int   prev_h = 0;

   // Each valid pops the oldest expected measurement
   always @(negedge clk) begin
      if (meas_valid) begin
         checks++;
         if (q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_valid at %0t: got period=%0d high_time=%0d, none expected",
                     $time, period, high_time);
         end else begin
            mon_e = q.pop_front();
            if (period !== CNT_W'(mon_e.p) || high_time !== CNT_W'(mon_e.h) ||
                locked !== mon_e.lk || timeout !== 1'b0) begin
               failures++;
               $display("FAIL meas at %0t: got p=%0d h=%0d lk=%0b to=%0b, want p=%0d h=%0d lk=%0b to=0",
                        $time, period, high_time, locked, timeout, mon_e.p, mon_e.h, mon_e.lk);
            end
         end
      end
   end

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Rising edge of a new cycle: completes the previous cycle's measurement
   function automatic void model_rise(input int p, input int h);
      bit ok;
      exp_t e;
      if (have_prev) begin
         ok        = (prev_p >= EXP - TOL) && (prev_p <= EXP + TOL);
         e.p       = prev_p;
         e.h       = prev_h;
         e.lk      = prev_ok_m && ok;
         prev_ok_m = ok;
         q.push_back(e);
      end
      have_prev = 1'b1;
      prev_p    = p;
      prev_h    = h;
   endfunction

   function automatic void model_reset();
      have_prev = 1'b0;
      prev_ok_m = 1'b0;
   endfunction

   task automatic send_cycle(input int p, input int h);
      sig_in = 1'b1;
      model_rise(p, h);
      wait_clk(h);
      sig_in = 1'b0;
      wait_clk(p - h);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      wait_clk(3);
      checks++;
      if ({period, high_time, meas_valid, locked, timeout} !== '0) begin
         failures++;
         $display("FAIL reset_state: got p=%0d h=%0d v=%0b lk=%0b to=%0b, want all 0",
                  period, high_time, meas_valid, locked, timeout);
      end
      rst_n = 1'b1;
      wait_clk(2);
      en = 1'b1;
      wait_clk(3);
   endtask

   task automatic test_lock();
      repeat (5) send_cycle(55, 28);
      checks++;
      if (locked !== 1'b1) begin
         failures++;
         $display("FAIL lock_acquire: got locked=%0b, want 1", locked);
      end
   endtask

   task automatic test_tolerance();
      send_cycle(57, 29);
      send_cycle(55, 28);
      send_cycle(55, 28);
      send_cycle(56, 28);
      send_cycle(54, 27);
      send_cycle(10, 5);
      send_cycle(55, 28);
      send_cycle(55, 28);
   endtask

   task automatic test_timeout();
      send_cycle(55, 28);
      send_cycle(55, 28);
      sig_in = 1'b1;
      model_rise(1128, 28);
      wait_clk(28);
      sig_in = 1'b0;
      wait_clk(1015 - 28);
      checks++;
      if (timeout !== 1'b0) begin
         failures++;
         $display("FAIL timeout_early: got timeout=%0b, want 0", timeout);
      end
      wait_clk(20);
      checks++;
      if (timeout !== 1'b1 || locked !== 1'b0 || high_time !== CNT_W'(28)) begin
         failures++;
         $display("FAIL timeout_fire: got to=%0b lk=%0b h=%0d, want to=1 lk=0 h=28",
                  timeout, locked, high_time);
      end
      model_reset();
      wait_clk(1128 - 1035);
      repeat (3) send_cycle(55, 28);
   endtask

   task automatic test_enable();
      repeat (3) send_cycle(55, 28);
      sig_in = 1'b1;
      model_rise(55, 28);
      wait_clk(8);
      en = 1'b0;
      wait_clk(3);
      checks++;
      if (locked !== 1'b0 || period !== CNT_W'(55) || timeout !== 1'b0) begin
         failures++;
         $display("FAIL enable_drop: got lk=%0b p=%0d to=%0b, want lk=0 p=55 to=0",
                  locked, period, timeout);
      end
      en = 1'b1;
      model_reset();
      wait_clk(17);
      sig_in = 1'b0;
      wait_clk(27);
      repeat (3) send_cycle(55, 28);
   endtask

   task automatic test_async_reset();
      repeat (2) send_cycle(55, 28);
      sig_in = 1'b1;
      model_rise(55, 28);
      wait_clk(28);
      sig_in = 1'b0;
      wait_clk(10);
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({period, high_time, meas_valid, locked, timeout} !== '0) begin
         failures++;
         $display("FAIL async_reset: got p=%0d h=%0d v=%0b lk=%0b to=%0b, want all 0",
                  period, high_time, meas_valid, locked, timeout);
      end
      model_reset();
      wait_clk(2);
      rst_n = 1'b1;
      wait_clk(15);
      repeat (3) send_cycle(55, 28);
   endtask

   task automatic test_dual_edge();
      en = 1'b0;
      wait_clk(5);
      model_reset();
      en = 1'b1;
      wait_clk(3);
      @(posedge clk);
      #1;
      // Divide-by-55, 50% duty: rises just after a posedge, falls just after a negedge
      repeat (5) begin
         sig_in = 1'b1;
         model_rise(110, 55);
         #275;
         sig_in = 1'b0;
         #275;
      end
      wait_clk(1);
      checks++;
      if (locked !== 1'b1) begin
         failures++;
         $display("FAIL dual_lock: got locked=%0b, want 1", locked);
      end
   endtask

   initial begin
      test_reset();
`ifdef DUAL_EDGE_EN
      test_dual_edge();
`else
      test_lock();
      test_tolerance();
      test_timeout();
      test_enable();
      test_async_reset();
`endif
      wait_clk(10);
      checks++;
      if (q.size() != 0) begin
         failures++;
         $display("FAIL missing_valid: got %0d outstanding expectations, want 0", q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
